rx_sample_arbiter: RTL and testbench

Round-robin scheduler that shares the single SMI sample-stream path between the two RX sample FIFOs (0.9 GHz and 2.4 GHz channels). It issues pull strobes to the FIFOs, captures the 32-bit I/Q word returned one cycle later, and presents it with a channel tag on a valid/ready interface to the SMI controller. Sits between the two RX FIFO read ports and the SMI controller, in the system clock domain.

---
 rtl/rx_arb_pkg.sv | 24 ++
 rtl/full_event_counter.sv | 40 ++++
 rtl/rx_sample_arbiter.sv | 154 +++++++++++++++
 tb/tb_rx_sample_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_arb_pkg.sv
// rx_arb_pkg
// Shared definitions for the RX sample arbiter: the scheduler state
// encoding, channel index constants, the default burst length and a
// helper that turns a channel index into its one-hot grant.
// Optional statistics are enabled with the RX_ARB_STATS_EN macro.
package rx_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULL  = 2'd1,
      LATCH = 2'd2,
      HOLD  = 2'd3
   } arb_state_t;

   localparam logic CH_09 = 1'b0;
   localparam logic CH_24 = 1'b1;

   localparam int BURST_LEN_DEF = 16;

   function automatic logic [1:0] ch_onehot(input logic ch);
      return ch ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/full_event_counter.sv
// full_event_counter
// Counts rising edges of a FIFO full flag with a saturating counter.
// Built only when RX_ARB_STATS_EN is defined.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   full  in   FIFO full flag
//   clr   in   counter clear, wins over a simultaneous edge
//   cnt   out  CNT_W-bit event count, saturates at all-ones
`ifdef RX_ARB_STATS_EN
module full_event_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             full,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic full_prev;
   logic rise;

   assign rise = full & ~full_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         full_prev <= 1'b0;
         cnt       <= '0;
      end else begin
         full_prev <= full;
         if (clr)
            cnt <= '0;
         else if (rise && !(&cnt))
            cnt <= cnt + 1'b1;
      end
   end

endmodule
`endif

// File: rtl/rx_sample_arbiter.sv
// rx_sample_arbiter
// Round-robin scheduler sharing the SMI sample path between the 0.9 GHz
// and 2.4 GHz RX FIFOs. Each transaction pulls one word from the granted
// FIFO, captures it the following cycle and holds it on a valid/ready
// interface until the consumer accepts it.
// Optional statistics (full-flag event counters) under RX_ARB_STATS_EN.
// Ports:
//   i_sys_clk, i_rst                  clock, synchronous active-high reset
//   i_en_09 / i_en_24                 per-channel enables
//   o_fifo_09_pull / o_fifo_24_pull   one-cycle FIFO read strobes
//   i_fifo_09_data / i_fifo_24_data   FIFO read data (valid cycle after pull)
//   i_fifo_09_empty / i_fifo_24_empty FIFO empty flags
//   i_fifo_09_full / i_fifo_24_full   FIFO full flags (statistics only)
//   o_data, o_ch, o_valid, i_ready    sample output handshake
//   o_grant                           one-hot grant, 0 when idle
//   i_stats_clr, o_full_cnt_09/24     statistics (RX_ARB_STATS_EN only)
module rx_sample_arbiter
   import rx_arb_pkg::*;
#(
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int CNT_W     = 16
) (
   input  logic             i_sys_clk,
   input  logic             i_rst,
   input  logic             i_en_09,
   input  logic             i_en_24,
   output logic             o_fifo_09_pull,
   output logic             o_fifo_24_pull,
   input  logic [31:0]      i_fifo_09_data,
   input  logic [31:0]      i_fifo_24_data,
   input  logic             i_fifo_09_empty,
   input  logic             i_fifo_24_empty,
   input  logic             i_fifo_09_full,
   input  logic             i_fifo_24_full,
   output logic [31:0]      o_data,
   output logic             o_ch,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [1:0]       o_grant
`ifdef RX_ARB_STATS_EN
   ,
   input  logic             i_stats_clr,
   output logic [CNT_W-1:0] o_full_cnt_09,
   output logic [CNT_W-1:0] o_full_cnt_24
`endif
);

   localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

   arb_state_t state, state_nxt;
   logic       cur_ch, cur_nxt;
   logic [7:0] burst_cnt, burst_nxt;
   logic [1:0] grant, grant_nxt;

   logic req_09, req_24, req_cur, req_oth;

   assign req_09  = i_en_09 & ~i_fifo_09_empty;
   assign req_24  = i_en_24 & ~i_fifo_24_empty;
   assign req_cur = (cur_ch == CH_24) ? req_24 : req_09;
   assign req_oth = (cur_ch == CH_24) ? req_09 : req_24;

   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         cur_ch    <= CH_09;
         burst_cnt <= '0;
         grant     <= '0;
      end else begin
         state     <= state_nxt;
         cur_ch    <= cur_nxt;
         burst_cnt <= burst_nxt;
         grant     <= grant_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cur_nxt   = cur_ch;
      burst_nxt = burst_cnt;
      grant_nxt = grant;
      case (state)
         IDLE: begin
            // Stay on the current channel until its burst is used up, then
            // hand over if the other side wants the path; a lone requester
            // starts a fresh burst.
            if (req_cur && (burst_cnt < BURST_MAX)) begin
               state_nxt = PULL;
               grant_nxt = ch_onehot(cur_ch);
            end else if (req_oth) begin
               state_nxt = PULL;
               cur_nxt   = ~cur_ch;
               burst_nxt = '0;
               grant_nxt = ch_onehot(~cur_ch);
            end else if (req_cur) begin
               state_nxt = PULL;
               burst_nxt = '0;
               grant_nxt = ch_onehot(cur_ch);
            end
         end
         PULL:  state_nxt = LATCH;
         LATCH: state_nxt = HOLD;
         HOLD: begin
            if (i_ready) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               if (burst_cnt < BURST_MAX)
                  burst_nxt = burst_cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // FIFO data arrives the cycle after the pull, i.e. while in LATCH.
   always_ff @(posedge i_sys_clk) begin
      if (i_rst) begin
         o_data <= '0;
         o_ch   <= CH_09;
      end else if (state == LATCH) begin
         o_data <= (cur_ch == CH_24) ? i_fifo_24_data : i_fifo_09_data;
         o_ch   <= cur_ch;
      end
   end

   assign o_fifo_09_pull = (state == PULL) && (cur_ch == CH_09);
   assign o_fifo_24_pull = (state == PULL) && (cur_ch == CH_24);
   assign o_valid        = (state == HOLD);
   assign o_grant        = grant;

`ifdef RX_ARB_STATS_EN
   full_event_counter #(.CNT_W(CNT_W)) u_cnt_09 (
      .clk  (i_sys_clk),
      .rst  (i_rst),
      .full (i_fifo_09_full),
      .clr  (i_stats_clr),
      .cnt  (o_full_cnt_09)
   );

   full_event_counter #(.CNT_W(CNT_W)) u_cnt_24 (
      .clk  (i_sys_clk),
      .rst  (i_rst),
      .full (i_fifo_24_full),
      .clr  (i_stats_clr),
      .cnt  (o_full_cnt_24)
   );
`else
   // Full flags only feed the statistics, which are not built here.
   logic [1:0]       unused_full;
   logic [CNT_W-1:0] unused_cnt_w;
   assign unused_full  = {i_fifo_09_full, i_fifo_24_full};
   assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_rx_sample_arbiter.sv
module tb_rx_sample_arbiter;

   localparam int BL    = 4;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, en09, en24, e09, e24, f09, f24, ready, clr;
   logic        pull09, pull24, valid, ch;
   logic [31:0] d09, d24, data;
   logic [1:0]  grant;
   logic [CNT_W-1:0] cnt09, cnt24;

   rx_sample_arbiter #(.BURST_LEN(BL), .CNT_W(CNT_W)) dut (
      .i_sys_clk       (clk),
      .i_rst           (rst),
      .i_en_09         (en09),
      .i_en_24         (en24),
      .o_fifo_09_pull  (pull09),
      .o_fifo_24_pull  (pull24),
      .i_fifo_09_data  (d09),
      .i_fifo_24_data  (d24),
      .i_fifo_09_empty (e09),
      .i_fifo_24_empty (e24),
      .i_fifo_09_full  (f09),
      .i_fifo_24_full  (f24),
      .o_data          (data),
      .o_ch            (ch),
      .o_valid         (valid),
      .i_ready         (ready),
      .o_grant         (grant)
`ifdef RX_ARB_STATS_EN
      ,
      .i_stats_clr     (clr),
      .o_full_cnt_09   (cnt09),
      .o_full_cnt_24   (cnt24)
`endif
   );

`ifndef RX_ARB_STATS_EN
   assign cnt09 = '0;
   assign cnt24 = '0;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // FIFO contents as seen by the environment
   logic [31:0] q09[$];
   logic [31:0] q24[$];

   // Transaction-level model: a transaction decided in cycle t0 pulls in
   // t0+1, is valid from t0+3 and ends at the accepting cycle.
   bit          m_busy, m_cur, m_ch, m_zero;
   int          m_t0, m_burst;
   logic [31:0] m_data;
   int          m_cnt09, m_cnt24;
   bit          m_prev09, m_prev24;

   logic        log_ch[$];
   logic [31:0] log_data[$];
   int          pull_cyc[$];
   int          n_pull24;
   bit          rand_mode;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic refresh();
      e09 = (q09.size() == 0);
      e24 = (q24.size() == 0);
   endtask

   task automatic model_adv();
      bit r0, r1, rc, ro, found, sel;
      if (rst) begin
         m_busy = 0; m_cur = 0; m_burst = 0; m_zero = 1;
         m_cnt09 = 0; m_cnt24 = 0; m_prev09 = 0; m_prev24 = 0;
         return;
      end
      m_zero = 0;
      if (valid && ready) begin
         log_ch.push_back(ch);
         log_data.push_back(data);
      end
      if (!m_busy) begin
         r0 = en09 && (q09.size() > 0);
         r1 = en24 && (q24.size() > 0);
         rc = m_cur ? r1 : r0;
         ro = m_cur ? r0 : r1;
         found = 1; sel = m_cur;
         if (rc && m_burst < BL) sel = m_cur;
         else if (ro) begin sel = !m_cur; m_burst = 0; end
         else if (rc) begin sel = m_cur; m_burst = 0; end
         else found = 0;
         if (found) begin
            m_busy = 1; m_t0 = cyc; m_ch = sel; m_cur = sel;
            m_data = sel ? q24[0] : q09[0];
         end
      end else if (cyc >= m_t0 + 3 && ready) begin
         m_busy = 0;
         m_burst = (m_burst + 1 > BL) ? BL : m_burst + 1;
      end
`ifdef RX_ARB_STATS_EN
      if (clr) m_cnt09 = 0;
      else if (f09 && !m_prev09 && m_cnt09 != 32'hFFFF) m_cnt09++;
      if (clr) m_cnt24 = 0;
      else if (f24 && !m_prev24 && m_cnt24 != 32'hFFFF) m_cnt24++;
      m_prev09 = f09;
      m_prev24 = f24;
`endif
   endtask

   task automatic check_cycle();
      bit ev;
      logic [1:0] eg;
      ev = m_busy && (cyc >= m_t0 + 3);
      chk("pull_09", 32'(pull09), 32'(m_busy && cyc == m_t0 + 1 && !m_ch));
      chk("pull_24", 32'(pull24), 32'(m_busy && cyc == m_t0 + 1 && m_ch));
      chk("valid", 32'(valid), 32'(ev));
      eg = (m_busy && cyc >= m_t0 + 1) ? (m_ch ? 2'b10 : 2'b01) : 2'b00;
      chk("grant", 32'(grant), 32'(eg));
      if (ev) begin
         chk("data", data, m_data);
         chk("ch", 32'(ch), 32'(m_ch));
      end
      if (m_zero) begin
         chk("rst_data", data, 32'h0);
         chk("rst_ch", 32'(ch), 32'h0);
      end
`ifdef RX_ARB_STATS_EN
      chk("cnt_09", 32'(cnt09), m_cnt09);
      chk("cnt_24", 32'(cnt24), m_cnt24);
`endif
   endtask

   task automatic fifo_react();
      if (pull09) begin
         chk("pull_09_nonempty", 32'(q09.size() != 0), 32'h1);
         if (q09.size() != 0) d09 = q09.pop_front();
         pull_cyc.push_back(cyc);
      end
      if (pull24) begin
         chk("pull_24_nonempty", 32'(q24.size() != 0), 32'h1);
         if (q24.size() != 0) d24 = q24.pop_front();
         n_pull24++;
      end
   endtask

   task automatic rand_inputs();
      if ($urandom_range(15) == 0) en09 = ~en09;
      if ($urandom_range(15) == 0) en24 = ~en24;
      if ($urandom_range(2) == 0 && q09.size() < 8) q09.push_back($urandom);
      if ($urandom_range(2) == 0 && q24.size() < 8) q24.push_back($urandom);
      ready = ($urandom_range(3) != 0);
      rst   = ($urandom_range(299) == 0);
      if ($urandom_range(7) == 0) f09 = ~f09;
      if ($urandom_range(7) == 0) f24 = ~f24;
      clr = ($urandom_range(49) == 0);
   endtask

   task automatic tick();
      refresh();
      model_adv();
      @(negedge clk);
      cyc++;
      check_cycle();
      fifo_react();
      if (rand_mode) rand_inputs();
      refresh();
   endtask

   task automatic clear_logs();
      log_ch.delete(); log_data.delete(); pull_cyc.delete(); n_pull24 = 0;
   endtask

   task automatic prep();
      en09 = 0; en24 = 0; ready = 1;
      q09.delete(); q24.delete();
      rst = 1;
      tick();
      rst = 0;
      clear_logs();
   endtask

   task automatic wait_log(input int n, input int bound);
      int k = 0;
      while (log_data.size() < n && k < bound) begin
         tick();
         k++;
      end
      if (log_data.size() < n) chk("timeout_samples", log_data.size(), n);
   endtask

   bit exp2[12] = '{0,0,0,0,1,1,1,1,0,0,0,0};
   bit exp3[16] = '{0,0,0,0,1,1,0,0,0,0,1,1,1,1,0,0};

   initial begin
      int k;
      bit pushed;
      rst = 1; en09 = 0; en24 = 0; ready = 0; f09 = 0; f24 = 0; clr = 0;
      d09 = '0; d24 = '0; rand_mode = 0; n_pull24 = 0;
      m_busy = 0; m_cur = 0; m_burst = 0; m_zero = 0; m_t0 = 0; m_ch = 0; m_data = '0;
      m_cnt09 = 0; m_cnt24 = 0; m_prev09 = 0; m_prev24 = 0;
      refresh();
      repeat (3) tick();
      chk("reset_valid", 32'(valid), 32'h0);
      chk("reset_grant", 32'(grant), 32'h0);
      chk("reset_data", data, 32'h0);
      chk("reset_pulls", 32'({pull09, pull24}), 32'h0);

      // Single channel, consumer always ready
      prep();
      for (int i = 0; i < 5; i++) q09.push_back(32'h11110000 + i);
      for (int i = 0; i < 3; i++) q24.push_back(32'hA0 + i);
      en09 = 1; en24 = 0; ready = 1;
      wait_log(5, 200);
      if (log_data.size() >= 5) begin
         chk("t1_d0", log_data[0], 32'h11110000);
         chk("t1_d1", log_data[1], 32'h11110001);
         chk("t1_d2", log_data[2], 32'h11110002);
         chk("t1_d3", log_data[3], 32'h11110003);
         chk("t1_d4", log_data[4], 32'h11110004);
         for (int i = 0; i < 5; i++) chk("t1_ch", 32'(log_ch[i]), 32'h0);
      end
      if (pull_cyc.size() >= 5)
         for (int i = 1; i < 5; i++) chk("t1_pull_gap", pull_cyc[i] - pull_cyc[i-1], 4);
      else
         chk("t1_pull_count", pull_cyc.size(), 5);
      chk("t1_no_24_pulls", n_pull24, 0);

      // Both channels busy: bursts of BL alternate
      prep();
      for (int i = 0; i < 12; i++) begin
         q09.push_back(32'h09000000 + i);
         q24.push_back(32'h24000000 + i);
      end
      en09 = 1; en24 = 1;
      wait_log(12, 300);
      if (log_ch.size() >= 12)
         for (int i = 0; i < 12; i++) chk("t2_ch_seq", 32'(log_ch[i]), 32'(exp2[i]));

      // 2.4 GHz runs dry after two samples, refilled later
      prep();
      for (int i = 0; i < 10; i++) q09.push_back(32'h09A00000 + i);
      for (int i = 0; i < 2; i++) q24.push_back(32'h24A00000 + i);
      en09 = 1; en24 = 1;
      pushed = 0; k = 0;
      while (log_data.size() < 16 && k < 400) begin
         tick();
         k++;
         if (!pushed && log_data.size() >= 7) begin
            for (int i = 0; i < 4; i++) q24.push_back(32'h24B00000 + i);
            pushed = 1;
            refresh();
         end
      end
      chk("t3_samples", log_data.size(), 16);
      if (log_ch.size() >= 16)
         for (int i = 0; i < 16; i++) chk("t3_ch_seq", 32'(log_ch[i]), 32'(exp3[i]));

      // Consumer stalls in HOLD
      prep();
      q09.push_back(32'hCAFE0001);
      en09 = 1; ready = 0;
      k = 0;
      while (!valid && k < 20) begin tick(); k++; end
      chk("t4_valid_seen", 32'(valid), 32'h1);
      for (int i = 0; i < 10; i++) begin
         q09.push_back(32'hBEEF0000 + i);
         tick();
         chk("t4_hold_data", data, 32'hCAFE0001);
         chk("t4_hold_nopull", 32'(pull09 | pull24), 32'h0);
      end
      ready = 1;
      tick();
      chk("t4_valid_drop", 32'(valid), 32'h0);

      // Reset while latching
      prep();
      for (int i = 0; i < 4; i++) begin
         q09.push_back(32'h5A000000 + i);
         q24.push_back(32'h5B000000 + i);
      end
      en09 = 1; en24 = 1;
      k = 0;
      while (!(pull09 || pull24) && k < 20) begin tick(); k++; end
      chk("t5_pull_seen", 32'(pull09 | pull24), 32'h1);
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("t5_rst_valid", 32'(valid), 32'h0);
      chk("t5_rst_data", data, 32'h0);
      chk("t5_rst_grant", 32'(grant), 32'h0);
      chk("t5_rst_pulls", 32'({pull09, pull24}), 32'h0);
      k = 0;
      while (!(pull09 || pull24) && k < 20) begin tick(); k++; end
      chk("t5_first_pull_09", 32'({pull09, pull24}), 32'h2);

`ifdef RX_ARB_STATS_EN
      // Full-flag event counting and clear priority
      prep();
      for (int i = 0; i < 3; i++) begin
         f09 = 1; tick();
         f09 = 0; tick();
      end
      chk("t6_cnt_09", 32'(cnt09), 32'd3);
      f09 = 1; clr = 1;
      tick();
      clr = 0; f09 = 0;
      chk("t6_clr_wins", 32'(cnt09), 32'd0);
`endif

      // Randomized traffic against the model
      prep();
      rand_mode = 1;
      repeat (3000) tick();
      rand_mode = 0;
      rst = 0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
